// File: rtl/fir_axis_out_fifo_if.sv
// AXI4-Stream bundle for the FIR output stage.
// Handshake: a beat transfers on a rising clk edge where tvalid & tready are
// both high. Once the master raises tvalid, it holds tvalid, tdata and tlast
// stable until that transfer happens. tready may change freely.
interface fir_axis_out_fifo_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/fir_axis_out_fifo.sv
// Output stage of the 4-tap Q1.15 FIR. It turns the FIR's push-only sample
// stream into an AXI4-Stream master through a first-word-fall-through FIFO.
// The FIR cannot stall. A sample that arrives while the FIFO is full and not
// popping is dropped and counted. TLAST marks every FRAME_LEN-th accepted
// sample.
module fir_axis_out_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int FRAME_LEN  = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  fir_axis_out_fifo_if.master      m_axis,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [CNT_WIDTH-1:0]     drop_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  // Each entry holds {tlast, sample}. The tlast bit is decided when the
  // sample is accepted, so drops never shift frame boundaries.
  logic [DATA_WIDTH:0] mem [DEPTH];

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [FCW-1:0] frame_cnt;

  logic full;
  logic pop;
  logic push;
  logic drop;
  logic frame_end;

  assign full      = (level == LW'(DEPTH));
  assign pop       = m_axis.tvalid & m_axis.tready;
  // A full FIFO that pops in the same cycle frees a slot, so it can accept
  // the write.
  assign push      = valid_in & (~full | pop);
  assign drop      = valid_in & ~push;
  assign frame_end = (frame_cnt == FCW'(FRAME_LEN - 1));

  // Head-of-FIFO view. It is forced to zero while empty, so tdata and tlast
  // read 0 after reset even though the storage itself is not cleared.
  assign m_axis.tvalid = (level != '0);
  assign m_axis.tdata  = m_axis.tvalid ? mem[rd_ptr][DATA_WIDTH-1:0] : '0;
  assign m_axis.tlast  = m_axis.tvalid ? mem[rd_ptr][DATA_WIDTH]     : 1'b0;

  // Sample storage, written on every accepted sample; no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {frame_end, data_in};
    end
  end

  // Pointers and occupancy. Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
    end
  end

  // Frame position among accepted samples; wraps on the sample that carries tlast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (push) begin
      frame_cnt <= frame_end ? '0 : frame_cnt + FCW'(1);
    end
  end

  // Drop bookkeeping. A drop in the same cycle as a clear wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      if (ovf_clr) begin
        drop_count <= drop ? CNT_WIDTH'(1) : '0;
      end else if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fir_axis_out_fifo.sv
// Bench for fir_axis_out_fifo: directed vectors plus a random tready run,
// checked against a reference queue of expected {tlast, data} beats.
module tb_fir_axis_out_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int FL    = 4;
  localparam int CW    = 4;
  localparam int MAXC  = 15;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in  = '0;
  logic          ovf_clr  = 1'b0;
  logic [3:0]    level;
  logic          overflow;
  logic [CW-1:0] drop_count;

  fir_axis_out_fifo_if #(.DATA_WIDTH(DW)) m_axis ();

  fir_axis_out_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .FRAME_LEN (FL),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .m_axis    (m_axis),
    .level     (level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .drop_count(drop_count)
  );

  // scoreboard state
  logic [DW:0]   exp_q[$];
  int            frame_pos = 0;
  logic          exp_ovf   = 1'b0;
  int            exp_drops = 0;
  logic          stalled   = 1'b0;
  logic [DW-1:0] held_d    = '0;
  logic          held_l    = 1'b0;
  logic          last_popped;
  logic [DW-1:0] last_pd;
  logic          last_pl;
  int            n_checks  = 0;
  int            n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, update the model.
  task automatic step(input logic vin, input logic [DW-1:0] din, input logic rdy, input logic clr);
    logic [DW:0] e;
    logic        pop_m;
    logic        push_m;
    logic        drop_m;
    int          sz;
    @(negedge clk);
    valid_in      = vin;
    data_in       = din;
    m_axis.tready = rdy;
    ovf_clr       = clr;
    #1;
    sz = exp_q.size();
    check("level", 32'(level), 32'(sz));
    check("tvalid", 32'(m_axis.tvalid), 32'(sz != 0));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("drop_count", 32'(drop_count), 32'(exp_drops));
    if (stalled) begin
      check("hold_tdata", 32'(m_axis.tdata), 32'(held_d));
      check("hold_tlast", 32'(m_axis.tlast), 32'(held_l));
    end
    pop_m       = (sz != 0) && rdy;
    last_popped = pop_m;
    last_pd     = m_axis.tdata;
    last_pl     = m_axis.tlast;
    if (pop_m) begin
      e = exp_q.pop_front();
      check("tdata", 32'(m_axis.tdata), 32'(e[DW-1:0]));
      check("tlast", 32'(m_axis.tlast), 32'(e[DW]));
    end
    stalled = (sz != 0) && !rdy;
    held_d  = m_axis.tdata;
    held_l  = m_axis.tlast;
    push_m  = vin && ((sz < DEPTH) || pop_m);
    drop_m  = vin && !push_m;
    if (push_m) begin
      exp_q.push_back({(frame_pos == FL - 1), din});
      frame_pos = (frame_pos == FL - 1) ? 0 : frame_pos + 1;
    end
    if (drop_m) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    if (clr) exp_drops = drop_m ? 1 : 0;
    else if (drop_m && exp_drops != MAXC) exp_drops++;
    @(posedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; released at a falling edge.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_tvalid"}, 32'(m_axis.tvalid), 32'd0);
    check({tag, "_level"}, 32'(level), 32'd0);
    exp_q.delete();
    frame_pos = 0;
    exp_ovf   = 1'b0;
    exp_drops = 0;
    stalled   = 1'b0;
    valid_in  = 1'b0;
    ovf_clr   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m_axis.tready = 1'b0;
    repeat (2) @(negedge clk);
    // reset values
    check("rst_tvalid", 32'(m_axis.tvalid), 32'd0);
    check("rst_tlast", 32'(m_axis.tlast), 32'd0);
    check("rst_tdata", 32'(m_axis.tdata), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    rst_n = 1'b1;

    // single sample, one-cycle FWFT latency
    step(1'b1, 16'h2000, 1'b1, 1'b0);
    check("t1_pop_empty", 32'(last_popped), 32'd0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("t1_pop", 32'(last_popped), 32'd1);
    check("t1_data", 32'(last_pd), 32'h2000);
    #1;
    check("t1_level", 32'(level), 32'd0);

    // fill under backpressure, ninth sample dropped
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    #1;
    check("t2_level_full", 32'(level), 32'd8);
    step(1'b1, 16'd9, 1'b0, 1'b0);
    #1;
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_drop_count", 32'(drop_count), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("t2_order", 32'(last_pd), 32'(i));
    end
    #1;
    check("t2_level_empty", 32'(level), 32'd0);

    // full FIFO with simultaneous pop and push
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'h0AFF, 1'b1, 1'b0);
    #1;
    check("t3_level", 32'(level), 32'd8);
    check("t3_no_drop", 32'(drop_count), 32'd0);
    check("t3_no_ovf", 32'(overflow), 32'd0);
    repeat (9) step(1'b0, 16'h0000, 1'b1, 1'b0);

    // framing: 10 samples, last two dropped, tlast on accepted #4 and #8
    mid_reset("t4_rst");
    for (int i = 0; i < 10; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    #1;
    check("t4_drops", 32'(drop_count), 32'd2);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("t4_pop", 32'(last_popped), 32'd1);
      check("t4_data", 32'(last_pd), 32'h0100 + 32'(i));
      check("t4_tlast", 32'(last_pl), 32'((i == 3) || (i == 7)));
    end

    // random backpressure against the reference queue
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 3) != 0), 16'($urandom_range(0, 65535)),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 63) == 0));
    end
    repeat (10) step(1'b0, 16'h0000, 1'b1, 1'b0);

    // drop counter saturation, then clear racing a drop
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0600 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 16'h0EEE, 1'b0, 1'b0);
    #1;
    check("t6_saturate", 32'(drop_count), 32'(MAXC));
    step(1'b1, 16'h0EEF, 1'b0, 1'b1);
    #1;
    check("t6_clr_drop_ovf", 32'(overflow), 32'd1);
    check("t6_clr_drop_cnt", 32'(drop_count), 32'd1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    #1;
    check("t6_clr_ovf", 32'(overflow), 32'd0);
    check("t6_clr_cnt", 32'(drop_count), 32'd0);

    // reset with a partly full FIFO, then traffic restarts at frame position 0
    mid_reset("t6_rst");
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0700 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("t6_tlast", 32'(last_pl), 32'(i == 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
